fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
//   IF stage of the pipelined MIPS core: owns the PC, drives a variable-latency
//   instruction-memory req/ack port, and loads the IF/ID register. Consumer of
//   the ID-stage next-PC resolver: takes its redirect (jump/taken branch/jr) and
//   annul (squash delay slot) signals, keeps the delay slot, then fetches the target.
// PARAMETERS
//   RESET_PC  32'h0000_3000  PC after reset
//   PC_LO     32'h0000_3000  lowest legal fetch address
//   PC_HI     32'h0000_6FFC  highest legal fetch address
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-high
//   stall        in   1   hazard unit: ID holds, IF/ID must not change
//   redirect     in   1   ID instr changes flow; valid only when stall=0
//   redirect_pc  in   32  target of redirect
//   annul        in   1   with redirect: delay slot becomes a bubble
//   imem_req     out  1   fetch request
//   imem_addr    out  32  fetch address (= PC)
//   imem_ack     in   1   rdata valid this cycle; may be same cycle as req
//   imem_rdata   in   32  instruction word
//   id_valid     out  1   IF/ID holds a live instruction
//   id_instr     out  32  IF/ID instruction (0 = nop when invalid)
//   id_pc        out  32  IF/ID PC
//   id_pc4       out  32  id_pc + 4
//   id_adel      out  1   IF/ID instr had fetch address error
// BEHAVIOUR
//   Reset (async): pc=RESET_PC, state=S_REQ, pend cleared, buffer cleared,
//     all id_* = 0; imem_req=0 while reset high.
//   FSM: S_REQ  imem_req=1, addr=pc; ack -> deliver; no ack -> S_WAIT.
//        S_WAIT imem_req=1, addr held; ack -> deliver.
//        S_HOLD imem_req=0; word in skid buffer; stall=0 -> buffer to IF/ID, S_REQ.
//   Deliver: stall=0 -> word to IF/ID (id_valid=1), pc updates, S_REQ;
//     stall=1 -> word to skid buffer, S_HOLD (pc not yet updated).
//   Next pc on delivery: pend_valid ? pend_pc : redirect ? redirect_pc : pc+4.
//   redirect/annul sampled only when stall=0. If no delivery that cycle, latch
//     pend_valid=1, pend_pc, pend_annul; cleared on next delivery.
//   Delivered word is the delay slot when redirect (same cycle) or pend_valid:
//     annul/pend_annul=1 -> id_valid=0, id_instr=0, id_pc still loaded.
//   stall=0 with no delivery: IF/ID <= bubble (id_valid=0, id_instr=0, id_adel=0).
//   stall=1: IF/ID holds every field.
//   Addr error: pc[1:0]!=0 or pc<PC_LO or pc>PC_HI in S_REQ -> no imem_req;
//     delivered internally that cycle as instr=0, id_adel=1, id_valid=1;
//     next pc rule unchanged.
//   pc+4 wraps modulo 2^32. Late ack after reset is memory's responsibility
//     (shares reset).
//   Latency: zero-wait memory, no stall -> one instruction/cycle; PC to IF/ID
//     is 1 edge.
// TESTING
//   T1 ack=1 always, stall=0 -> id_pc 0x3000,0x3004,0x3008 on successive
//      edges, id_pc4=id_pc+4, id_valid=1.
//   T2 ack withheld 2 cycles at 0x3004 -> imem_addr=0x3004 for 3 cycles,
//      id_valid=0 for 2 edges, then id_pc=0x3004.
//   T3 ID at 0x3008 drives redirect=1, redirect_pc=0x3100 -> 0x300C enters
//      ID valid, next fetch 0x3100.
//   T4 as T3 with annul=1 and ack delayed 1 cycle -> pend latched; 0x300C
//      loaded with id_valid=0, id_instr=0; then fetch 0x3100.
//   T5 stall=1 as 0x3010 acks -> S_HOLD, imem_req=0, IF/ID frozen 3 cycles;
//      stall=0 -> id_pc=0x3010 next edge, imem_addr=0x3014.
//   T6 redirect_pc=0x3002 -> no req, id_adel=1, id_pc=0x3002; reset pulse in
//      S_WAIT -> pc=0x3000, id_valid=0 immediately.

Source files
------------

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master: it raises req with addr. The memory answers
// with ack and rdata, either in the same cycle or a number of cycles later.
interface fetch_unit_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/fetch_unit.sv
// IF stage of the pipelined MIPS core. It owns the PC, fetches through a
// variable-latency req/ack port and loads the IF/ID register. A redirect from
// ID keeps the delay slot and then fetches the target. An annul turns that
// delay slot into a bubble.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] PC_LO    = 32'h0000_3000,
    parameter logic [31:0] PC_HI    = 32'h0000_6FFC
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall_i,
    input  logic          redirect_i,
    input  logic [31:0]   redirect_pc_i,
    input  logic          annul_i,
    fetch_unit_if.master  imem,
    output logic          id_valid_o,
    output logic [31:0]   id_instr_o,
    output logic [31:0]   id_pc_o,
    output logic [31:0]   id_pc4_o,
    output logic          id_adel_o
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_annul_q, pend_annul_d;
    logic [31:0] buf_instr_q, buf_instr_d;
    logic        buf_adel_q, buf_adel_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_pc4_q, id_pc4_d;
    logic        id_adel_q, id_adel_d;

    logic        addr_err;
    logic        req_c;
    logic        deliver;
    logic        load_id;
    logic        kill;
    logic [31:0] del_instr;
    logic        del_adel;

    // A misaligned or out-of-window PC is never sent to memory.
    assign addr_err = (pc_q[1:0] != 2'b00) || (pc_q < PC_LO) || (pc_q > PC_HI);

    // Request is suppressed while reset is asserted, independent of state.
    assign imem.req  = req_c && !rst;
    assign imem.addr = pc_q;

    // Next-state logic: find a word this cycle, then route it to IF/ID or the skid buffer.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pend_valid_d = pend_valid_q;
        pend_pc_d    = pend_pc_q;
        pend_annul_d = pend_annul_q;
        buf_instr_d  = buf_instr_q;
        buf_adel_d   = buf_adel_q;
        id_valid_d   = id_valid_q;
        id_instr_d   = id_instr_q;
        id_pc_d      = id_pc_q;
        id_pc4_d     = id_pc4_q;
        id_adel_d    = id_adel_q;
        req_c        = 1'b0;
        deliver      = 1'b0;
        del_instr    = 32'h0;
        del_adel     = 1'b0;

        case (state_q)
            S_REQ: begin
                if (addr_err) begin
                    // A bad address produces its own word in the same cycle: a nop tagged adel.
                    deliver  = 1'b1;
                    del_adel = 1'b1;
                end else begin
                    req_c = 1'b1;
                    if (imem.ack) begin
                        deliver   = 1'b1;
                        del_instr = imem.rdata;
                    end
                end
            end
            S_WAIT: begin
                req_c = 1'b1;
                if (imem.ack) begin
                    deliver   = 1'b1;
                    del_instr = imem.rdata;
                end
            end
            S_HOLD: begin
                if (!stall_i) begin
                    deliver   = 1'b1;
                    del_instr = buf_instr_q;
                    del_adel  = buf_adel_q;
                end
            end
            default: state_d = S_REQ;
        endcase

        load_id = deliver && !stall_i;
        // The delivered word is a delay slot if a redirect is pending or arrives now.
        kill    = pend_valid_q ? pend_annul_q : (redirect_i && annul_i);

        if (load_id) begin
            id_valid_d   = !kill;
            id_instr_d   = kill ? 32'h0 : del_instr;
            id_adel_d    = del_adel && !kill;
            id_pc_d      = pc_q;
            id_pc4_d     = pc_q + 32'd4;
            pc_d         = pend_valid_q ? pend_pc_q :
                           redirect_i   ? redirect_pc_i : pc_q + 32'd4;
            pend_valid_d = 1'b0;
            pend_annul_d = 1'b0;
            state_d      = S_REQ;
        end else if (!stall_i) begin
            // No word for ID this cycle: insert a bubble and remember any redirect.
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
            id_adel_d  = 1'b0;
            if (redirect_i && !pend_valid_q) begin
                pend_valid_d = 1'b1;
                pend_pc_d    = redirect_pc_i;
                pend_annul_d = annul_i;
            end
            if (state_q == S_REQ) state_d = S_WAIT;
        end else begin
            // ID is stalled: a word that arrives now waits in the skid buffer.
            if (deliver) begin
                buf_instr_d = del_instr;
                buf_adel_d  = del_adel;
                state_d     = S_HOLD;
            end else if (state_q == S_REQ) begin
                state_d = S_WAIT;
            end
        end
    end

    // State, PC, pending-redirect, skid-buffer and IF/ID registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_pc_q    <= 32'h0;
            pend_annul_q <= 1'b0;
            buf_instr_q  <= 32'h0;
            buf_adel_q   <= 1'b0;
            id_valid_q   <= 1'b0;
            id_instr_q   <= 32'h0;
            id_pc_q      <= 32'h0;
            id_pc4_q     <= 32'h0;
            id_adel_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_pc_q    <= pend_pc_d;
            pend_annul_q <= pend_annul_d;
            buf_instr_q  <= buf_instr_d;
            buf_adel_q   <= buf_adel_d;
            id_valid_q   <= id_valid_d;
            id_instr_q   <= id_instr_d;
            id_pc_q      <= id_pc_d;
            id_pc4_q     <= id_pc4_d;
            id_adel_q    <= id_adel_d;
        end
    end

    assign id_valid_o = id_valid_q;
    assign id_instr_o = id_instr_q;
    assign id_pc_o    = id_pc_q;
    assign id_pc4_o   = id_pc4_q;
    assign id_adel_o  = id_adel_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. It runs a directed per-cycle vector table, a few
// hand-written reset sequences, and then a randomized run. The randomized run
// checks the design against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, redirect, annul;
    logic [31:0] redirect_pc;
    logic        id_valid, id_adel;
    logic [31:0] id_instr, id_pc, id_pc4;

    int total = 0;
    int bad   = 0;

    fetch_unit_if imem ();

    fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .annul_i       (annul),
        .imem          (imem),
        .id_valid_o    (id_valid),
        .id_instr_o    (id_instr),
        .id_pc_o       (id_pc),
        .id_pc4_o      (id_pc4),
        .id_adel_o     (id_adel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        rd;
        logic [31:0] rpc;
        logic        an;
        logic        ak;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_adel;
    } vec_t;

    vec_t vecs [20];

    // Memory contents: each word is derived from its own address.
    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {~a[15:0], a[15:0]};
    endfunction

    function automatic logic legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && (a >= 32'h3000) && (a <= 32'h6FFC);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                                input logic an, input logic ak, input logic rq,
                                input logic [31:0] ad, input logic v,
                                input logic [31:0] p, input logic adl);
        vec_t r;
        r.st = st; r.rd = rd; r.rpc = rpc; r.an = an; r.ak = ak;
        r.exp_req = rq; r.exp_addr = ad; r.exp_valid = v; r.exp_pc = p; r.exp_adel = adl;
        return r;
    endfunction

    // Applies one table row. It is entered and left at a falling edge.
    task automatic run_row(input vec_t v, input int idx);
        logic [31:0] ei;
        stall       = v.st;
        redirect    = v.rd;
        redirect_pc = v.rpc;
        annul       = v.an;
        imem.ack    = v.ak;
        imem.rdata  = v.ak ? word_of(imem.addr) : $urandom;
        #1;
        chk($sformatf("row%0d req", idx), 32'(imem.req), 32'(v.exp_req));
        chk($sformatf("row%0d addr", idx), imem.addr, v.exp_addr);
        @(posedge clk);
        #1;
        ei = (v.exp_valid && !v.exp_adel) ? word_of(v.exp_pc) : 32'h0;
        chk($sformatf("row%0d id_valid", idx), 32'(id_valid), 32'(v.exp_valid));
        chk($sformatf("row%0d id_pc", idx), id_pc, v.exp_pc);
        chk($sformatf("row%0d id_pc4", idx), id_pc4, v.exp_pc + 32'd4);
        chk($sformatf("row%0d id_instr", idx), id_instr, ei);
        chk($sformatf("row%0d id_adel", idx), 32'(id_adel), 32'(v.exp_adel));
        $display("row %0d: addr=%08h id_valid=%0d id_pc=%08h id_adel=%0d",
                 idx, imem.addr, id_valid, id_pc, id_adel);
        @(negedge clk);
    endtask

    // Reference model state for the randomized run.
    logic [31:0] m_pc, m_word, m_pend_pc;
    logic        m_have, m_adel, m_pend, m_pend_annul;
    logic        m_valid, m_id_adel;
    logic [31:0] m_instr, m_id_pc, m_id_pc4;

    initial begin
        rst = 1'b1;
        stall = 1'b0; redirect = 1'b0; annul = 1'b0; redirect_pc = 32'h0;
        imem.ack = 1'b0; imem.rdata = 32'h0;

        //            st rd rpc          an ak req addr          v  pc           adel
        vecs[0]  = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3000, Y, 32'h0000_3000, N);
        vecs[1]  = mk(N, N, 32'h0,       N, N, Y, 32'h0000_3004, N, 32'h0000_3000, N);
        vecs[2]  = mk(N, N, 32'h0,       N, N, Y, 32'h0000_3004, N, 32'h0000_3000, N);
        vecs[3]  = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3004, Y, 32'h0000_3004, N);
        vecs[4]  = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3008, Y, 32'h0000_3008, N);
        vecs[5]  = mk(N, Y, 32'h3100,    N, Y, Y, 32'h0000_300C, Y, 32'h0000_300C, N);
        vecs[6]  = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3100, Y, 32'h0000_3100, N);
        vecs[7]  = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3104, Y, 32'h0000_3104, N);
        vecs[8]  = mk(N, Y, 32'h3200,    Y, N, Y, 32'h0000_3108, N, 32'h0000_3104, N);
        vecs[9]  = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3108, N, 32'h0000_3108, N);
        vecs[10] = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3200, Y, 32'h0000_3200, N);
        vecs[11] = mk(Y, N, 32'h0,       N, Y, Y, 32'h0000_3204, Y, 32'h0000_3200, N);
        vecs[12] = mk(Y, N, 32'h0,       N, N, N, 32'h0000_3204, Y, 32'h0000_3200, N);
        vecs[13] = mk(Y, N, 32'h0,       N, N, N, 32'h0000_3204, Y, 32'h0000_3200, N);
        vecs[14] = mk(N, N, 32'h0,       N, N, N, 32'h0000_3204, Y, 32'h0000_3204, N);
        vecs[15] = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3208, Y, 32'h0000_3208, N);
        vecs[16] = mk(N, Y, 32'h3002,    N, Y, Y, 32'h0000_320C, Y, 32'h0000_320C, N);
        vecs[17] = mk(N, N, 32'h0,       N, N, N, 32'h0000_3002, Y, 32'h0000_3002, Y);
        vecs[18] = mk(N, Y, 32'h3300,    N, N, N, 32'h0000_3006, Y, 32'h0000_3006, Y);
        vecs[19] = mk(N, N, 32'h0,       N, Y, Y, 32'h0000_3300, Y, 32'h0000_3300, N);

        // Reset state.
        @(negedge clk);
        chk("reset req", 32'(imem.req), 32'h0);
        chk("reset addr", imem.addr, 32'h0000_3000);
        chk("reset id_valid", 32'(id_valid), 32'h0);
        chk("reset id_pc", id_pc, 32'h0);
        chk("reset id_instr", id_instr, 32'h0);
        chk("reset id_pc4", id_pc4, 32'h0);
        chk("reset id_adel", 32'(id_adel), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 20; i++) run_row(vecs[i], i);

        // Reset asserted while waiting on an ack.
        stall = 1'b0; redirect = 1'b0; annul = 1'b0; imem.ack = 1'b0;
        @(negedge clk);
        chk("wait req", 32'(imem.req), 32'h1);
        chk("wait addr", imem.addr, 32'h0000_3304);
        rst = 1'b1;
        #1;
        chk("async rst req", 32'(imem.req), 32'h0);
        chk("async rst addr", imem.addr, 32'h0000_3000);
        chk("async rst id_valid", 32'(id_valid), 32'h0);
        chk("async rst id_pc", id_pc, 32'h0);
        $display("reset in wait: addr=%08h id_valid=%0d", imem.addr, id_valid);
        @(negedge clk);
        rst = 1'b0;
        imem.ack = 1'b1;
        imem.rdata = word_of(32'h0000_3000);
        #1;
        chk("post rst addr", imem.addr, 32'h0000_3000);
        @(posedge clk);
        #1;
        chk("post rst id_pc", id_pc, 32'h0000_3000);
        chk("post rst id_valid", 32'(id_valid), 32'h1);
        chk("post rst id_instr", id_instr, word_of(32'h0000_3000));
        $display("after reset: id_pc=%08h id_valid=%0d", id_pc, id_valid);
        @(negedge clk);

        // Randomized run against the reference model.
        rst = 1'b1; imem.ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_pc = 32'h3000; m_have = 1'b0; m_word = 32'h0; m_adel = 1'b0;
        m_pend = 1'b0; m_pend_pc = 32'h0; m_pend_annul = 1'b0;
        m_valid = 1'b0; m_instr = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_id_adel = 1'b0;
        begin
            int          wcnt;
            int          lat;
            logic        ereq, ack, avail, kill, a;
            logic [31:0] w;
            int          sel;
            wcnt = 0;
            lat  = $urandom_range(0, 2);
            for (int c = 0; c < 1500; c++) begin
                stall    = ($urandom_range(0, 3) == 0);
                redirect = !stall && !m_pend && ($urandom_range(0, 5) == 0);
                annul    = $urandom_range(0, 1) == 1;
                sel      = $urandom_range(0, 9);
                case (sel)
                    0:       redirect_pc = 32'h3000 + ($urandom_range(0, 16'h3FFF) | 32'h1);
                    1:       redirect_pc = 32'hFFFF_FFFC;
                    2:       redirect_pc = 32'h0000_7000;
                    3:       redirect_pc = 32'h0000_2FFC;
                    default: redirect_pc = 32'h3000 + ($urandom_range(0, 12'hFFF) << 2);
                endcase
                ereq = !m_have && legal(m_pc);
                ack  = ereq && (wcnt >= lat);
                imem.ack   = ack;
                imem.rdata = ack ? word_of(m_pc) : $urandom;
                #1;
                chk($sformatf("rand%0d req", c), 32'(imem.req), 32'(ereq));
                chk($sformatf("rand%0d addr", c), imem.addr, m_pc);
                if (ereq) begin
                    if (ack) begin
                        wcnt = 0;
                        lat  = $urandom_range(0, 2);
                    end else begin
                        wcnt++;
                    end
                end
                // Advance the model across this clock edge.
                avail = m_have || !legal(m_pc) || ack;
                w     = m_have ? m_word : (legal(m_pc) ? word_of(m_pc) : 32'h0);
                a     = m_have ? m_adel : !legal(m_pc);
                if (!stall) begin
                    if (avail) begin
                        kill      = m_pend ? m_pend_annul : (redirect && annul);
                        m_valid   = !kill;
                        m_instr   = kill ? 32'h0 : w;
                        m_id_adel = a && !kill;
                        m_id_pc   = m_pc;
                        m_id_pc4  = m_pc + 32'd4;
                        m_pc      = m_pend ? m_pend_pc : (redirect ? redirect_pc : m_pc + 32'd4);
                        m_pend    = 1'b0;
                        m_have    = 1'b0;
                    end else begin
                        m_valid   = 1'b0;
                        m_instr   = 32'h0;
                        m_id_adel = 1'b0;
                        if (redirect && !m_pend) begin
                            m_pend       = 1'b1;
                            m_pend_pc    = redirect_pc;
                            m_pend_annul = annul;
                        end
                    end
                end else if (avail && !m_have) begin
                    m_have = 1'b1;
                    m_word = w;
                    m_adel = a;
                end
                @(posedge clk);
                #1;
                chk($sformatf("rand%0d id_valid", c), 32'(id_valid), 32'(m_valid));
                chk($sformatf("rand%0d id_instr", c), id_instr, m_instr);
                chk($sformatf("rand%0d id_pc", c), id_pc, m_id_pc);
                chk($sformatf("rand%0d id_pc4", c), id_pc4, m_id_pc4);
                chk($sformatf("rand%0d id_adel", c), 32'(id_adel), 32'(m_id_adel));
                $display("rand %0d: st=%0d rd=%0d ack=%0d id_valid=%0d id_pc=%08h id_adel=%0d",
                         c, stall, redirect, ack, id_valid, id_pc, id_adel);
                @(negedge clk);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Keeps the run bounded even if the sequence above stops advancing.
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
